adder_frame_master: RTL
=======================

ADDER_FRAME_MASTER -- requirements
Module: adder_frame_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed while waiting on tx_done_i or rx_dv_i before abort.
REQ-002 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  single-cycle request to run one transaction.
REQ-005 SHALL have a_i, b_i  input  64 each  operands, sampled on accepted start.
REQ-006 SHALL have busy  output  1  high from accepted start until the done pulse.
REQ-007 SHALL have done  output  1  one-cycle pulse at end of transaction.
REQ-008 SHALL have result_o  output  64  last good sum; status_o  output  2  00 ok, 01 device reported error (EE), 10 response checksum mismatch, 11 timeout.
REQ-009 SHALL have tx_dv_o  output  1  one-cycle byte-send strobe; tx_byte_o  output  8  byte to send; tx_done_i  input  1  UART TX byte-complete pulse.
REQ-010 SHALL have rx_dv_i  input  1  UART RX byte-valid pulse; rx_byte_i  input  8  received byte.

Function
REQ-011 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-012 SHALL send a 19-byte request frame in order: FD, BA, a[7:0]..a[63:56], b[7:0]..b[63:56], checksum; byte k of a word = bits [8k+7:8k].
REQ-013 Checksum SHALL be the mod-256 sum of all preceding frame bytes, header included.
REQ-014 SHALL assert tx_dv_o for exactly one cycle per byte, with tx_byte_o stable from that cycle until tx_done_i; the next byte SHALL NOT be strobed before tx_done_i for the previous one.
REQ-015 The first tx_dv_o SHALL occur in the cycle after start is accepted; each subsequent tx_dv_o SHALL occur in the cycle after the previous tx_done_i.
REQ-016 rx_dv_i pulses during the send phase SHALL be discarded.
REQ-017 State sequence: IDLE -> SEND -> WAIT_TX -> (SEND, repeated for 19 bytes) -> RX_HDR0 -> RX_HDR1 -> RX_DATA (8 bytes) -> RX_CSUM -> FINISH -> IDLE.
REQ-018 RX_HDR0: byte EE -> FINISH, status 01; byte FD -> RX_HDR1; any other byte -> ignored, remain.
REQ-019 RX_HDR1: byte BA -> RX_DATA; any other byte -> RX_HDR0.
REQ-020 RX_DATA SHALL assemble 8 bytes LSB-first into a shadow register and accumulate the running checksum starting at FD+BA (B7).
REQ-021 RX_CSUM: received byte equal to the running checksum -> result_o <= shadow, status 00; otherwise status 10 and result_o unchanged.
REQ-022 The timeout counter SHALL clear on each tx_done_i, each consumed rx_dv_i, and on start; on reaching TIMEOUT_CYCLES in any non-IDLE state -> FINISH, status 11.
REQ-023 FINISH SHALL pulse done for one cycle, deassert busy in that same cycle, and return to IDLE; status_o and result_o SHALL hold until the next completion.
REQ-024 A start coincident with the done cycle SHALL be ignored.
REQ-025 Operands SHALL be latched at start; a_i/b_i changes during busy SHALL NOT affect the frame.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE: busy=0, done=0, tx_dv_o=0, tx_byte_o=00, result_o=0, status_o=00, counters and checksums cleared, including mid-transaction.
REQ-027 After reset release, the first transaction SHALL behave identically to one started from power-up.

Verification
REQ-028 a=1, b=2, start -> tx bytes FD BA 01 00x7 02 00x7 BA; then reply FD BA 03 00x7 BA -> done, result_o=3, status_o=00.
REQ-029 a=FFFFFFFFFFFFFFFF, b=1 -> request checksum = mod-256 sum of FD, BA, FFx8, 01, 00x7 = B0; reply FD BA 00x8 B7 -> result_o=0, status_o=00.
REQ-030 Any request; reply EE -> done, status_o=01, result_o unchanged from prior value.
REQ-031 Reply with noise 12 FD 00, then FD BA 03 00x7 with checksum 00 -> noise skipped, status_o=10, result_o unchanged.
REQ-032 TIMEOUT_CYCLES=100; tx_done_i withheld after the 5th byte -> done 100 cycles later, status_o=11; second start during busy ignored.
REQ-033 rst_n low after the 10th tx_done_i -> outputs at reset values same cycle; a new start sends a full, correct 19-byte frame.

Source files
------------

// File: rtl/adder_frame_master_if.sv
// adder_frame_master_if: request/result and UART byte-stream signals of the adder frame master
interface adder_frame_master_if;
    logic        start;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        busy;
    logic        done;
    logic [63:0] result_o;
    logic [1:0]  status_o;
    logic        tx_dv_o;
    logic [7:0]  tx_byte_o;
    logic        tx_done_i;
    logic        rx_dv_i;
    logic [7:0]  rx_byte_i;
    modport master (
        input  start, a_i, b_i, tx_done_i, rx_dv_i, rx_byte_i,
        output busy, done, result_o, status_o, tx_dv_o, tx_byte_o
    );
    modport slave (
        output start, a_i, b_i, tx_done_i, rx_dv_i, rx_byte_i,
        input  busy, done, result_o, status_o, tx_dv_o, tx_byte_o
    );
endinterface

// File: rtl/adder_frame_master.sv
// adder_frame_master: sends a,b to a UART adder as a checksummed frame and collects the checked sum
module adder_frame_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_frame_master_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RX_HDR0, RX_HDR1, RX_DATA, RX_CSUM, FINISH} state_e;
    state_e        state_q, state_d;
    logic [127:0]  ops_q, ops_d;
    logic [63:0]   shadow_q, shadow_d, result_q, result_d;
    logic [7:0]    tx_byte_q, tx_byte_d, csum_q, csum_d, nxt_byte;
    logic [4:0]    idx_q, idx_d;
    logic [1:0]    status_q, status_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_hit, clr, tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            shadow_q  <= '0;
            result_q  <= '0;
            tx_byte_q <= '0;
            csum_q    <= '0;
            idx_q     <= '0;
            status_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            shadow_q  <= shadow_d;
            result_q  <= result_d;
            tx_byte_q <= tx_byte_d;
            csum_q    <= csum_d;
            idx_q     <= idx_d;
            status_q  <= status_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        shadow_d  = shadow_q;
        result_d  = result_q;
        tx_byte_d = tx_byte_q;
        csum_d    = csum_q;
        idx_d     = idx_q;
        status_d  = status_q;
        rx_hit    = bus.rx_dv_i && (state_q inside {RX_HDR0, RX_HDR1, RX_DATA, RX_CSUM});
        clr       = rx_hit || bus.tx_done_i;
        tmo_d     = (state_q == IDLE || clr) ? '0 : tmo_q + 1'b1;
        tmo_hit   = state_q != IDLE && state_q != FINISH && !clr && tmo_q == TW'(TIMEOUT_CYCLES - 1);
        // byte following frame position idx_q; operands are consumed from the bottom of ops_q
        nxt_byte  = idx_q == 5'd0 ? 8'hBA : idx_q == 5'd17 ? csum_q : ops_q[7:0];
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = SEND;
                ops_d     = {bus.b_i, bus.a_i};
                tx_byte_d = 8'hFD;
                csum_d    = 8'hFD;
                idx_d     = '0;
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: if (bus.tx_done_i) begin
                if (idx_q == 5'd18) state_d = RX_HDR0;
                else begin
                    state_d   = SEND;
                    idx_d     = idx_q + 1'b1;
                    tx_byte_d = nxt_byte;
                    csum_d    = csum_q + nxt_byte;
                    ops_d     = idx_q == 5'd0 ? ops_q : ops_q >> 8;
                end
            end
            RX_HDR0: if (rx_hit) begin
                state_d  = bus.rx_byte_i == 8'hEE ? FINISH : bus.rx_byte_i == 8'hFD ? RX_HDR1 : RX_HDR0;
                status_d = bus.rx_byte_i == 8'hEE ? 2'b01 : status_q;
            end
            RX_HDR1: if (rx_hit) begin
                state_d = bus.rx_byte_i == 8'hBA ? RX_DATA : RX_HDR0;
                csum_d  = 8'hB7;
                idx_d   = '0;
            end
            RX_DATA: if (rx_hit) begin
                shadow_d = {bus.rx_byte_i, shadow_q[63:8]};
                csum_d   = csum_q + bus.rx_byte_i;
                idx_d    = idx_q + 1'b1;
                state_d  = idx_q == 5'd7 ? RX_CSUM : RX_DATA;
            end
            RX_CSUM: if (rx_hit) begin
                state_d  = FINISH;
                status_d = bus.rx_byte_i == csum_q ? 2'b00 : 2'b10;
                result_d = bus.rx_byte_i == csum_q ? shadow_q : result_q;
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d  = FINISH;
            status_d = 2'b11;
        end
    end

    assign bus.busy      = state_q != IDLE && state_q != FINISH;
    assign bus.done      = state_q == FINISH;
    assign bus.tx_dv_o   = state_q == SEND;
    assign bus.tx_byte_o = tx_byte_q;
    assign bus.result_o  = result_q;
    assign bus.status_o  = status_q;
endmodule
